osd_char_overlay: RTL and testbench

- Upstream of `osd_rom`: drives its 11-bit address from live video timing and consumes its 8-bit `rd_data`.
- Blends a 1-bit-per-pixel character bitmap, in a fixed rectangular window, onto a 24-bit RGB stream. Set pixels become `FG_COLOR`; clear pixels pass video through.
- Sits in the HDMI output path between the video timing/pattern source and the HDMI encoder; all video signals are delayed by a constant 3 clocks.

---
 rtl/osd_char_overlay.sv | 146 ++++++++++++++
 tb/tb_osd_char_overlay.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/osd_char_overlay.sv
// Overlays a 1bpp character bitmap from a synchronous ROM onto an RGB stream inside a fixed window.
// Latency is 3 clocks for video and timing. Throughput is 1 pixel/clock. There is no backpressure.
module osd_char_overlay #(
  parameter int unsigned OSD_X    = 32,
  parameter int unsigned OSD_Y    = 32,
  parameter int unsigned OSD_W    = 256,
  parameter int unsigned OSD_H    = 64,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        osd_en,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [23:0] rgb_out
);

  localparam logic [11:0] WIN_X = 12'(OSD_X);
  localparam logic [11:0] WIN_Y = 12'(OSD_Y);
  localparam logic [11:0] WIN_W = 12'(OSD_W);
  localparam logic [11:0] WIN_H = 12'(OSD_H);
  localparam logic [11:0] BPL   = 12'(OSD_W / 8);

  logic [11:0] x_cnt;
  logic [11:0] y_cnt;
  logic [11:0] x_rel;
  logic [11:0] y_rel;
  logic        de_d1;
  logic        vs_act;
  logic        vs_act_d1;
  logic        osd_en_f;
  logic        in_win;
  logic [23:0] addr_full;

  logic        win1;
  logic [2:0]  bsel1;
  logic        hs1;
  logic        vs1;
  logic        de1;
  logic [23:0] rgb1;
  logic        win2;
  logic [2:0]  bsel2;
  logic        hs2;
  logic        vs2;
  logic        de2;
  logic [23:0] rgb2;
  logic        pix_on;

  assign vs_act = (vs_in == VS_POL);

  // Unsigned wrap makes coordinates before the window edge look huge, so one compare bounds both sides
  assign x_rel  = x_cnt - WIN_X;
  assign y_rel  = y_cnt - WIN_Y;
  assign in_win = de_in & osd_en_f & (x_rel < WIN_W) & (y_rel < WIN_H);

  assign addr_full = {12'd0, y_rel} * {12'd0, BPL} + {15'd0, x_rel[11:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= 12'd0;
      y_cnt     <= 12'd0;
      de_d1     <= 1'b0;
      vs_act_d1 <= 1'b0;
      osd_en_f  <= 1'b0;
    end else begin
      x_cnt     <= de_in ? x_cnt + 12'd1 : 12'd0;
      de_d1     <= de_in;
      vs_act_d1 <= vs_act;
      if (vs_act) begin
        y_cnt <= 12'd0;
      end else if (de_d1 && !de_in && (y_cnt != 12'hFFF)) begin
        y_cnt <= y_cnt + 12'd1;
      end
      if (vs_act && !vs_act_d1) begin
        osd_en_f <= osd_en;
      end
    end
  end

  // S1: the address goes out to the ROM, and video is captured alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= 11'd0;
      win1     <= 1'b0;
      bsel1    <= 3'd0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      de1      <= 1'b0;
      rgb1     <= 24'd0;
    end else begin
      if (in_win) begin
        rom_addr <= addr_full[10:0];
      end
      win1  <= in_win;
      bsel1 <= x_rel[2:0];
      hs1   <= hs_in;
      vs1   <= vs_in;
      de1   <= de_in;
      rgb1  <= rgb_in;
    end
  end

  // S2: the ROM samples rom_addr on this edge, and its byte is ready for S3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win2  <= 1'b0;
      bsel2 <= 3'd0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      de2   <= 1'b0;
      rgb2  <= 24'd0;
    end else begin
      win2  <= win1;
      bsel2 <= bsel1;
      hs2   <= hs1;
      vs2   <= vs1;
      de2   <= de1;
      rgb2  <= rgb1;
    end
  end

  assign pix_on = win2 & rom_data[3'd7 - bsel2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      de_out  <= 1'b0;
      rgb_out <= 24'd0;
    end else begin
      hs_out  <= hs2;
      vs_out  <= vs2;
      de_out  <= de2;
      rgb_out <= pix_on ? FG_COLOR : rgb2;
    end
  end

endmodule

// File: tb/tb_osd_char_overlay.sv
// Scoreboard bench: two overlay instances (a mid-frame window and a bottom-right edge window) are driven by the same 64x16 frames.
module tb_osd_char_overlay;

  localparam int AX = 8;
  localparam int AY = 2;
  localparam int AW = 16;
  localparam int AH = 4;
  localparam int BX = 56;
  localparam int BY = 14;
  localparam int BW = 8;
  localparam int BH = 2;
  localparam logic [23:0] FG = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        osd_en = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic [23:0] rgb_in = 24'd0;

  logic [10:0] rom_addr_a, rom_addr_b;
  logic [7:0]  rom_data_a = 8'd0;
  logic [7:0]  rom_data_b = 8'd0;
  logic        hs_out_a, vs_out_a, de_out_a;
  logic        hs_out_b, vs_out_b, de_out_b;
  logic [23:0] rgb_out_a, rgb_out_b;

  always #5 clk = ~clk;

  osd_char_overlay #(.OSD_X(AX), .OSD_Y(AY), .OSD_W(AW), .OSD_H(AH), .FG_COLOR(FG), .VS_POL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .osd_en(osd_en), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .hs_out(hs_out_a),
    .vs_out(vs_out_a), .de_out(de_out_a), .rgb_out(rgb_out_a)
  );

  osd_char_overlay #(.OSD_X(BX), .OSD_Y(BY), .OSD_W(BW), .OSD_H(BH), .FG_COLOR(FG), .VS_POL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .osd_en(osd_en), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .hs_out(hs_out_b),
    .vs_out(vs_out_b), .de_out(de_out_b), .rgb_out(rgb_out_b)
  );

  // 1-cycle synchronous ROM: either a constant A5 pattern or data equal to the low byte of the address
  bit rom_mode = 1'b0;
  always @(posedge clk) begin
    rom_data_a <= rom_mode ? rom_addr_a[7:0] : 8'hA5;
    rom_data_b <= rom_mode ? rom_addr_b[7:0] : 8'hA5;
  end

  typedef struct {
    int          cyc;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
  } vid_exp_t;

  typedef struct {
    int          cyc;
    logic [10:0] a;
    logic [10:0] b;
  } adr_exp_t;

  vid_exp_t vq[$];
  adr_exp_t aq[$];
  vid_exp_t mv;
  adr_exp_t ma;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  bit          frame_en = 1'b0;
  bit          prev_vs = 1'b0;
  bit          push_en = 1'b1;
  logic [10:0] last_a = 11'd0;
  logic [10:0] last_b = 11'd0;
  logic [23:0] pix = 24'd0;
  logic [23:0] row2_tbl [8] = '{FG, 24'h0, FG, 24'h0, 24'h0, FG, 24'h0, FG};

  function automatic bit in_w(input int x, input int y, input int px, input int py, input int w, input int h);
    return (x >= px) && (x < px + w) && (y >= py) && (y < py + h);
  endfunction

  function automatic logic [10:0] waddr(input int x, input int y, input int px, input int py, input int w);
    return 11'((y - py) * (w / 8) + (x - px) / 8);
  endfunction

  function automatic logic [23:0] blend(input logic [10:0] ad, input int x, input int px,
                                        input logic [23:0] rgb, input bit mode);
    logic [7:0] byt;
    bit         b;
    byt = mode ? ad[7:0] : 8'hA5;
    b   = byt[7 - ((x - px) % 8)];
    return b ? FG : rgb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Drive one pixel clock and push what each instance should show 3 cycles later (rom_addr: 1 cycle later)
  task automatic step(input logic hs, input logic vs, input logic de, input logic [23:0] rgb,
                      input int x, input int y);
    vid_exp_t v;
    adr_exp_t a;
    bit       wa, wb;
    @(posedge clk);
    #1;
    hs_in  = hs;
    vs_in  = vs;
    de_in  = de;
    rgb_in = rgb;
    if (vs && !prev_vs) frame_en = osd_en;
    prev_vs = vs;
    wa = de && frame_en && in_w(x, y, AX, AY, AW, AH);
    wb = de && frame_en && in_w(x, y, BX, BY, BW, BH);
    v.cyc = cyc; v.hs = hs; v.vs = vs; v.de = de;
    v.rgb_a = rgb;
    v.rgb_b = rgb;
    if (wa) begin
      last_a  = waddr(x, y, AX, AY, AW);
      v.rgb_a = blend(last_a, x, AX, rgb, rom_mode);
      if (!rom_mode && rgb == 24'h0 && y == AY && x < AX + 8) v.rgb_a = row2_tbl[x - AX];
    end
    if (wb) begin
      last_b  = waddr(x, y, BX, BY, BW);
      v.rgb_b = blend(last_b, x, BX, rgb, rom_mode);
    end
    a.cyc = cyc;
    a.a   = last_a;
    a.b   = last_b;
    if (wa && rom_mode && y == 3 && x == 17) a.a = 11'd3;
    if (push_en) begin
      vq.push_back(v);
      aq.push_back(a);
    end
  endtask

  // One 64x16 frame with 8-pixel h-blank and 2 v-blank lines. A negative line number disables the toggle or the reset.
  task automatic frame(input bit cnt_rgb, input int toggle_line, input int rst_line, input int rst_col);
    push_en = 1'b1;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 72; c++) step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    for (int y = 0; y < 16; y++) begin
      if (y == toggle_line) osd_en = 1'b1;
      for (int c = 0; c < 72; c++) begin
        if (y == rst_line && c == rst_col - 5) push_en = 1'b0;
        pix = pix + 24'd1;
        step((c >= 66 && c < 70), 1'b0, (c < 64), cnt_rgb ? pix : 24'h0, c, y);
        if (y == rst_line && c == rst_col) begin
          rst_n    = 1'b0;
          frame_en = 1'b0;
          last_a   = 11'd0;
          last_b   = 11'd0;
        end
        if (y == rst_line && c == rst_col + 2) rst_n = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          64'({hs_out_a, vs_out_a, de_out_a, rgb_out_a, hs_out_b, vs_out_b, de_out_b, rgb_out_b}), 64'd0);
      chk("reset_rom_addr", 64'({rom_addr_a, rom_addr_b}), 64'd0);
    end else begin
      while (vq.size() > 0 && vq[0].cyc + 3 < cyc) begin
        mv = vq.pop_front();
        chk("video_missed", 64'(mv.cyc), 64'(cyc - 3));
      end
      if (vq.size() > 0 && vq[0].cyc + 3 == cyc) begin
        mv = vq.pop_front();
        chk("rgb_a", 64'(rgb_out_a), 64'(mv.rgb_a));
        chk("rgb_b", 64'(rgb_out_b), 64'(mv.rgb_b));
        chk("timing_a", 64'({hs_out_a, vs_out_a, de_out_a}), 64'({mv.hs, mv.vs, mv.de}));
        chk("timing_b", 64'({hs_out_b, vs_out_b, de_out_b}), 64'({mv.hs, mv.vs, mv.de}));
      end
      while (aq.size() > 0 && aq[0].cyc + 1 < cyc) begin
        ma = aq.pop_front();
        chk("addr_missed", 64'(ma.cyc), 64'(cyc - 1));
      end
      if (aq.size() > 0 && aq[0].cyc + 1 == cyc) begin
        ma = aq.pop_front();
        chk("rom_addr_a", 64'(rom_addr_a), 64'(ma.a));
        chk("rom_addr_b", 64'(rom_addr_b), 64'(ma.b));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rom_mode = 1'b0; osd_en = 1'b0;
    frame(1'b1, -1, -1, -1);          // passthrough
    osd_en = 1'b1;
    frame(1'b0, -1, -1, -1);          // A5 bit pattern
    rom_mode = 1'b1;
    frame(1'b1, -1, -1, -1);          // address walk, ROM data = address
    rom_mode = 1'b0; osd_en = 1'b0;
    frame(1'b0, 3, -1, -1);           // enable raised mid-frame: no overlay yet
    frame(1'b0, -1, -1, -1);          // overlay from the next frame
    frame(1'b0, -1, 3, 12);           // reset pulse inside the window
    frame(1'b0, -1, -1, -1);          // recovers to the A5 pattern frame
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(vq.size() + aq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
